prod_accum: RTL
===============

// Module: prod_accum
// PURPOSE
//  Downstream stage of the 32x32 unsigned array multiplier. Consumes each 64-bit product
//  over a valid/ready handshake and accumulates a block of products (dot-product style).
//  On the product flagged last, it emits the block sum, the term count and an overflow flag.
//  Output uses valid/ready; the accumulator restarts at zero for the next block.
// PARAMETERS
//  PW  64  product width (matches multiplier output s)
//  AW  72  accumulator/result width, AW >= PW; sum wraps modulo 2^AW
//  CW  16  term-counter width
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active high
//  in_valid   in   1   in_prod/in_last valid this cycle
//  in_ready   out  1   stage can accept a product this cycle
//  in_prod    in   PW  unsigned product from multiplier
//  in_last    in   1   this product closes the current block
//  out_valid  out  1   out_acc/out_count/out_ovf hold a finished block
//  out_ready  in   1   consumer takes the result this cycle
//  out_acc    out  AW  block sum (unsigned)
//  out_count  out  CW  number of products in the block
//  out_ovf    out  1   sum exceeded 2^AW-1 at least once in the block
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): acc=0, cnt=0, ovf=0, out_valid=0, out_acc=0, out_count=0,
//    out_ovf=0. Reset mid-block discards the partial sum. Reset with out_valid=1 drops the result.
//  - in_ready = !out_valid || out_ready (combinational). in_ready does not depend on in_valid.
//  - Input accept: in_valid && in_ready at a clk edge.
//  - Accept with in_last=0: acc <= (acc + zext(in_prod)) mod 2^AW.
//    cnt <= cnt+1, saturating at 2^CW-1. ovf <= ovf | carry-out of the AW-bit add.
//  - Accept with in_last=1: out_acc <= acc+in_prod and out_count <= cnt+1 (saturating).
//    out_ovf <= ovf|carry. out_valid <= 1. acc, cnt and ovf clear to 0 in the same edge.
//  - Latency: the result appears one cycle after the last beat is accepted. A single-beat block
//    (in_last on the first beat) gives out_acc=in_prod and out_count=1.
//  - Output handshake: out_valid && out_ready pops the result.
//    - If no new last beat is accepted on the same edge, out_valid <= 0.
//    - If one is accepted, the output registers reload and out_valid stays 1 (back-to-back).
//  - While out_valid=1 and out_ready=0: in_ready=0. out_acc, out_count and out_ovf hold stable.
//    No product is accepted and none is lost.
//  - in_valid=0: no state change except the output pop. The bench must not change in_prod while
//    in_valid=1 and in_ready=0 (same rule as upstream).
//  - Two states, derived from out_valid:
//    - EMPTY (out_valid=0) -> FULL on an accepted last beat.
//    - FULL -> EMPTY on a pop with no last beat accepted.
//    - FULL -> FULL on a pop together with a last beat, or on no pop.
//  - Outputs are registered; there is no combinational in->out path except in_ready<-out_ready.
// TESTING
//  1 Reset: hold rst 2 cycles -> out_valid=0, out_acc=0, out_count=0, out_ovf=0, in_ready=1.
//  2 Block of 3, out_ready=1: prods 6, 35, 0xFFFF_FFFE_0000_0001 (last) ->
//    out_acc=0xFFFF_FFFE_0000_002A, out_count=3, out_ovf=0, one cycle after the last beat.
//  3 Backpressure: finish block {5(last)}, hold out_ready=0 for 4 cycles -> in_ready=0 and
//    out_acc=5 stable. Then out_ready=1 with {7(last)} on the same cycle -> out_acc=7 next cycle,
//    out_valid stays 1.
//  4 Overflow: AW=64 build, prods 0xFFFF_FFFF_FFFF_FFFF then 2 (last) -> out_acc=1, out_ovf=1.
//    The next block {3(last)} -> out_ovf=0.
//  5 Reset mid-block: accept 9, 9, assert rst, then {4(last)} -> out_acc=4, out_count=1.
//  6 Random: 1000 blocks of 1..20 products with random in_valid/out_ready -> every result matches
//    the model sum mod 2^AW and the model count; no beat dropped or duplicated.

Source files
------------

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - accumulates a block of multiplier products and emits sum, term count and overflow
module prod_accum #(
  parameter int PW = 64,
  parameter int AW = 72,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_acc,
  output logic [CW-1:0] out_count,
  output logic          out_ovf
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] out_acc_q, out_acc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          out_ovf_q, out_ovf_d;

  logic [AW:0]   sum_w;
  logic [CW-1:0] cnt_inc;
  logic          accept;
  logic          accept_last;

  // Extra top bit of the add is the carry-out that feeds the sticky overflow flag.
  assign sum_w       = {1'b0, acc_q} + (AW+1)'(in_prod);
  assign cnt_inc     = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
  assign out_valid   = (state_q == S_FULL);
  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign accept_last = accept && in_last;
  assign out_acc     = out_acc_q;
  assign out_count   = out_cnt_q;
  assign out_ovf     = out_ovf_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_acc_d = out_acc_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;

    if (accept) begin
      if (in_last) begin
        out_acc_d = sum_w[AW-1:0];
        out_cnt_d = cnt_inc;
        out_ovf_d = ovf_q | sum_w[AW];
        acc_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
      end else begin
        acc_d = sum_w[AW-1:0];
        cnt_d = cnt_inc;
        ovf_d = ovf_q | sum_w[AW];
      end
    end

    case (state_q)
      S_EMPTY: if (accept_last) state_d = S_FULL;
      S_FULL:  if (out_ready && !accept_last) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_acc_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_acc_q <= out_acc_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule
